// File: rtl/prog_cache.sv
// Direct-mapped instruction cache: 1-cycle synchronous lookup, single-line
// refill from the SDRAM controller through a mem_req/mem_ack/mem_rvalid handshake.
module prog_cache #(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned OFFS_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] prg_address,
  output logic [15:0] instruction,
  output logic        p_cache_miss,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned TAG_W = 32 - INDEX_W - OFFS_W;
  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << (INDEX_W + OFFS_W);

  typedef enum logic [1:0] {LOOKUP, REQ, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic [OFFS_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                flushed_q, flushed_d;
  logic                fresh_q, fresh_d;

  logic [15:0]         data_ram [WORDS];
  logic [TAG_W-1:0]    tag_ram  [LINES];
  logic [15:0]         instr_q;

  logic [INDEX_W-1:0]  index_q, fill_index;
  logic [TAG_W-1:0]    tag_q;
  logic                hit;
  logic                ram_we, tag_we, rd_en;

  assign index_q    = addr_q[OFFS_W +: INDEX_W];
  assign tag_q      = addr_q[31 -: TAG_W];
  assign fill_index = mem_addr_q[OFFS_W +: INDEX_W];
  assign hit        = valid_q[index_q] & (tag_ram[index_q] == tag_q);
  assign rd_en      = (state_q == LOOKUP);

  // fresh_q marks that addr_q/instr_q were loaded in LOOKUP; the first cycle
  // back from DONE still holds the stale address, so it is reported as a miss.
  assign p_cache_miss = ~hit | (state_q != LOOKUP) | ~fresh_q;
  assign instruction  = instr_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    flushed_d  = flushed_q;
    fresh_d    = (state_q == LOOKUP);
    ram_we     = 1'b0;
    tag_we     = 1'b0;
    case (state_q)
      LOOKUP: begin
        addr_d = prg_address;
        if (fresh_q && !hit) begin
          state_d                   = REQ;
          mem_req_d                 = 1'b1;
          mem_addr_d                = addr_q;
          mem_addr_d[OFFS_W-1:0]    = '0;
          flushed_d                 = 1'b0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d   = FILL;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = DONE;
        end
      end
      DONE: begin
        tag_we = 1'b1;
        if (!flushed_q) valid_d[fill_index] = 1'b1;
        state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase
    // Flush takes priority over the DONE validation of the fill line.
    if (flush) begin
      valid_d = '0;
      if (state_q != LOOKUP) flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOOKUP;
      addr_q     <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      cnt_q      <= '0;
      valid_q    <= '0;
      flushed_q  <= 1'b0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      flushed_q  <= flushed_d;
      fresh_q    <= fresh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) data_ram[{fill_index, cnt_q}] <= mem_rdata;
    if (rd_en)  instr_q <= data_ram[prg_address[INDEX_W+OFFS_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_ram[fill_index] <= mem_addr_q[31 -: TAG_W];
  end

endmodule

// File: tb/tb_prog_cache.sv
// Directed bench for prog_cache: cold miss, hit stream, conflict, flush
// during fill, slow ack with stray rvalid, and reset during fill.
module tb_prog_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] prg_address;
  logic [15:0] instruction;
  logic        p_cache_miss;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int n_chk  = 0;
  int n_fail = 0;

  prog_cache #(.INDEX_W(5), .OFFS_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .prg_address  (prg_address),
    .instruction  (instruction),
    .p_cache_miss (p_cache_miss),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for a fill request, acknowledges it after ack_delay cycles and
  // returns the four words base..base+3; ends sampled in DONE.
  task automatic serve_fill(input logic [31:0] exp_addr, input logic [15:0] base,
                            input int ack_delay, input int flush_word, input bit stray);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
    chk("req_seen", mem_req, 1);
    chk("req_addr", mem_addr, exp_addr);
    for (int i = 0; i < ack_delay; i++) begin
      mem_rvalid = stray && (i == 3 || i == 6);
      mem_rdata  = 16'hDEAD;
      tick();
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, exp_addr);
    end
    mem_rvalid = 1'b0;
    mem_ack    = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("req_drop", mem_req, 0);
    for (int w = 0; w < 4; w++) begin
      mem_rdata  = base + 16'(w);
      mem_rvalid = 1'b1;
      flush      = (w == flush_word);
      tick();
    end
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    chk("done_miss", p_cache_miss, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; prg_address = 32'h5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miss", p_cache_miss, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;

    // Cold miss on 0x5
    serve_fill(32'h4, 16'hA000, 0, -1, 1'b0);
    tick();
    chk("cold_l1_miss", p_cache_miss, 1);
    tick();
    chk("cold_hit", p_cache_miss, 0);
    chk("cold_instr", instruction, 16'hA001);

    // Hit stream 0x4..0x7
    for (int a = 4; a < 8; a++) begin
      prg_address = 32'(a);
      tick();
      chk("stream_instr", instruction, 16'hA000 + 16'(a - 4));
      chk("stream_miss", p_cache_miss, 0);
      chk("stream_req", mem_req, 0);
    end

    // Conflict on index 1
    prg_address = 32'h84;
    tick();
    chk("conf_miss", p_cache_miss, 1);
    serve_fill(32'h84, 16'hB000, 0, -1, 1'b0);
    tick();
    tick();
    chk("conf_hit", p_cache_miss, 0);
    chk("conf_instr", instruction, 16'hB000);
    prg_address = 32'h4;
    tick();
    chk("conf_remiss", p_cache_miss, 1);
    serve_fill(32'h4, 16'hC000, 0, -1, 1'b0);
    tick();
    tick();
    chk("refill_hit", p_cache_miss, 0);
    chk("refill_instr", instruction, 16'hC000);

    // Flush during word 2 of a fill
    prg_address = 32'h8;
    tick();
    chk("fl_miss", p_cache_miss, 1);
    serve_fill(32'h8, 16'hD000, 0, 2, 1'b0);
    tick();
    chk("fl_l1_miss", p_cache_miss, 1);
    tick();
    chk("fl_l2_miss", p_cache_miss, 1);
    serve_fill(32'h8, 16'hD100, 0, -1, 1'b0);
    tick();
    tick();
    chk("fl_refill_hit", p_cache_miss, 0);
    chk("fl_refill_instr", instruction, 16'hD100);
    prg_address = 32'h4;
    tick();
    chk("fl_other_line", p_cache_miss, 1);

    // Slow ack with stray rvalid while in REQ
    serve_fill(32'h4, 16'hE000, 10, -1, 1'b1);
    prg_address = 32'h6;
    tick();
    tick();
    chk("slow_hit", p_cache_miss, 0);
    chk("slow_instr", instruction, 16'hE002);
    prg_address = 32'h4;
    tick();
    chk("slow_instr0", instruction, 16'hE000);

    // Reset after word 1 of a fill
    prg_address = 32'h10;
    tick();
    chk("rf_miss", p_cache_miss, 1);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
    chk("rf_req", mem_req, 1);
    chk("rf_addr", mem_addr, 32'h10);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 16'h1111; mem_rvalid = 1'b1;
    tick();
    mem_rdata = 16'h2222;
    tick();
    mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rf_rst_req", mem_req, 0);
    chk("rf_rst_miss", p_cache_miss, 1);
    tick();
    rst = 1'b0;
    prg_address = 32'h6;
    serve_fill(32'h4, 16'hF000, 0, -1, 1'b0);
    prg_address = 32'h11;
    tick();
    tick();
    chk("rf_partial_miss", p_cache_miss, 1);
    serve_fill(32'h10, 16'h3000, 0, -1, 1'b0);
    tick();
    tick();
    chk("rf_final_hit", p_cache_miss, 0);
    chk("rf_final_instr", instruction, 16'h3001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
